volume_control: RTL and testbench

//  Turns the raw volume-up/volume-down push-buttons into a saturating volume level.

---
 rtl/volume_control.sv | 179 +++++++++++++++++
 tb/tb_volume_control.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/volume_control.sv
// Volume control: synchronises and debounces the up/down push-buttons, then
// steps a saturating volume level with auto-repeat while a button is held.
module volume_control #(
  parameter int VOL_W           = 4,
  parameter int VOL_MAX         = 15,
  parameter int VOL_DEFAULT     = 8,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [VOL_W-1:0] volume,
  output logic             mudou_volume,
  output logic             at_max,
  output logic             at_min
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SETTLE  = DEBOUNCE_CYCLES + 6;
  localparam int SET_W   = $clog2(SETTLE + 1);

  localparam logic [VOL_W-1:0] MAX_V    = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0] DEF_V    = VOL_W'(VOL_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] T_DELAY  = TMR_W'(REPEAT_DELAY);
  localparam logic [TMR_W-1:0] T_PERIOD = TMR_W'(REPEAT_PERIOD);
  localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
  localparam logic [SET_W-1:0] SETTLE_V = SET_W'(SETTLE);

  typedef enum logic [1:0] {IDLE, WAIT, REPEAT, BLOCK} state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]       sync1, sync2, deb;
  logic [CNT_W-1:0] cnt [2];
  logic [SET_W-1:0] settle;
  logic             hold_off;
  logic             deb_up, deb_down;

  state_t           state, state_next;
  logic             dir, dir_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             step, step_down;
  logic             held, other;

  logic [VOL_W-1:0] vol_next;
  logic             pulse_next;

  assign deb_up   = deb[0];
  assign deb_down = deb[1];
  assign hold_off = (settle != SETTLE_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_DONE) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Covers the window in which a button held through reset can still debounce high.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle <= '0;
    end else if (settle != SETTLE_V) begin
      settle <= settle + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dir   <= 1'b0;
      timer <= '0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      timer <= timer_next;
    end
  end

  assign held  = dir ? deb_down : deb_up;
  assign other = dir ? deb_up : deb_down;

  always_comb begin
    state_next = state;
    dir_next   = dir;
    timer_next = timer;
    step       = 1'b0;
    step_down  = dir;
    case (state)
      IDLE: begin
        if ((deb_up && deb_down) || (hold_off && (deb_up || deb_down))) begin
          state_next = BLOCK;
        end else if (deb_up || deb_down) begin
          step       = 1'b1;
          step_down  = deb_down;
          dir_next   = deb_down;
          timer_next = T_DELAY;
          state_next = WAIT;
        end
      end
      WAIT, REPEAT: begin
        if (!held) begin
          state_next = IDLE;
        end else if (other) begin
          state_next = BLOCK;
        end else if (timer == T_ONE) begin
          step       = 1'b1;
          timer_next = T_PERIOD;
          state_next = REPEAT;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      BLOCK: begin
        if (!deb_up && !deb_down) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating step: a blocked step neither changes volume nor pulses.
  always_comb begin
    vol_next   = volume;
    pulse_next = 1'b0;
    if (step) begin
      if (step_down && (volume != '0)) begin
        vol_next   = volume - 1'b1;
        pulse_next = 1'b1;
      end else if (!step_down && (volume != MAX_V)) begin
        vol_next   = volume + 1'b1;
        pulse_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      volume       <= DEF_V;
      mudou_volume <= 1'b0;
      at_max       <= (DEF_V == MAX_V);
      at_min       <= (DEF_V == '0);
    end else begin
      volume       <= vol_next;
      mudou_volume <= pulse_next;
      at_max       <= (vol_next == MAX_V);
      at_min       <= (vol_next == '0);
    end
  end

endmodule

// File: tb/tb_volume_control.sv
// Testbench for volume_control: directed scenarios with fixed expectations plus
// a randomized phase compared cycle by cycle against a behavioural model.
module tb_volume_control;

  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int VMAX = 15;
  localparam int VDEF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] volume;
  logic       mudou_volume;
  logic       at_max;
  logic       at_min;

  int assertions = 0;
  int failures   = 0;
  int pidx[$];
  int edge_no;

  volume_control #(
    .VOL_W(4), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF),
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .volume(volume), .mudou_volume(mudou_volume), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  // Behavioural model: sync is a 2-sample delay, a level is accepted once the
  // last D+1 synchronised samples all disagree with it, and a held button steps
  // at hold ages 0, RD, RD+RP, RD+2*RP, ...
  bit m_s1[2], m_s2[2], m_deb[2], deb_o[2];
  bit m_hist[2][D+1];
  bit all_diff, m_pulse, m_hold;
  int m_mode, m_dir, m_age, m_since, m_vol;

  function void m_step();
    if (m_dir == 0 && m_vol < VMAX) begin
      m_vol   = m_vol + 1;
      m_pulse = 1'b1;
    end else if (m_dir == 1 && m_vol > 0) begin
      m_vol   = m_vol - 1;
      m_pulse = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0;
        for (int i = 0; i <= D; i++) m_hist[b][i] = 0;
      end
      m_mode = 0; m_dir = 0; m_age = 0; m_since = 0;
      m_vol = VDEF; m_pulse = 0;
    end else begin
      deb_o = m_deb;
      for (int b = 0; b < 2; b++) begin
        for (int i = D; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = m_s2[b];
        all_diff = 1'b1;
        for (int i = 0; i <= D; i++) if (m_hist[b][i] == deb_o[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = !deb_o[b];
      end
      m_s2 = m_s1;
      m_s1[0] = btn_up;
      m_s1[1] = btn_down;
      m_pulse = 1'b0;
      m_hold  = (m_since < D + 6);
      if (m_since < 1000) m_since++;
      case (m_mode)
        0: begin
          if ((deb_o[0] && deb_o[1]) || (m_hold && (deb_o[0] || deb_o[1]))) begin
            m_mode = 2;
          end else if (deb_o[0] || deb_o[1]) begin
            m_dir  = deb_o[1] ? 1 : 0;
            m_mode = 1;
            m_age  = 0;
            m_step();
          end
        end
        1: begin
          if (!deb_o[m_dir]) m_mode = 0;
          else if (deb_o[1-m_dir]) m_mode = 2;
          else begin
            m_age++;
            if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) m_step();
          end
        end
        default: if (!deb_o[0] && !deb_o[1]) m_mode = 0;
      endcase
    end
  end

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mudou_volume) pidx.push_back(edge_no);
      edge_no++;
    end
  endtask

  task automatic press(input logic up, input logic dn, input int hold, input int after);
    @(negedge clk);
    pidx.delete();
    edge_no  = 0;
    btn_up   = up;
    btn_down = dn;
    watch(hold);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    watch(after);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    repeat (2) @(negedge clk);
    assertions++; if (volume !== 4'd8) begin failures++; $display("[TB] FAIL reset_volume: got %0d, expected 8", volume); end
    assertions++; if (mudou_volume !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulse: got %b, expected 0", mudou_volume); end
    assertions++; if (at_max !== 1'b0) begin failures++; $display("[TB] FAIL reset_at_max: got %b, expected 0", at_max); end
    assertions++; if (at_min !== 1'b0) begin failures++; $display("[TB] FAIL reset_at_min: got %b, expected 0", at_min); end
    reset = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_glitch();
    press(1'b1, 1'b0, 3, 20);
    assertions++; if (pidx.size() != 0) begin failures++; $display("[TB] FAIL glitch_pulses: got %0d, expected 0", pidx.size()); end
    assertions++; if (volume !== 4'd8) begin failures++; $display("[TB] FAIL glitch_volume: got %0d, expected 8", volume); end
  endtask

  task automatic test_single_step();
    press(1'b1, 1'b0, 8, 20);
    assertions++; if (pidx.size() != 1) begin failures++; $display("[TB] FAIL single_pulses: got %0d, expected 1", pidx.size()); end
    assertions++; if (pidx.size() < 1 || pidx[0] != D + 3) begin failures++; $display("[TB] FAIL single_latency: got edge %0d, expected %0d", (pidx.size() > 0) ? pidx[0] : -1, D + 3); end
    assertions++; if (volume !== 4'd9) begin failures++; $display("[TB] FAIL single_volume: got %0d, expected 9", volume); end
  endtask

  task automatic test_repeat_down();
    press(1'b0, 1'b1, 40, 20);
    assertions++; if (pidx.size() != 9) begin failures++; $display("[TB] FAIL repeat_pulses: got %0d, expected 9", pidx.size()); end
    assertions++; if (pidx.size() < 3 || pidx[0] != 7 || pidx[1] != 17 || pidx[2] != 20) begin failures++; $display("[TB] FAIL repeat_timing: got first edges %0d %0d %0d, expected 7 17 20", (pidx.size() > 0) ? pidx[0] : -1, (pidx.size() > 1) ? pidx[1] : -1, (pidx.size() > 2) ? pidx[2] : -1); end
    assertions++; if (volume !== 4'd0) begin failures++; $display("[TB] FAIL repeat_volume: got %0d, expected 0", volume); end
  endtask

  task automatic test_at_min();
    press(1'b0, 1'b1, 20, 20);
    assertions++; if (pidx.size() != 0) begin failures++; $display("[TB] FAIL min_pulses: got %0d, expected 0", pidx.size()); end
    assertions++; if (volume !== 4'd0) begin failures++; $display("[TB] FAIL min_volume: got %0d, expected 0", volume); end
    assertions++; if (at_min !== 1'b1) begin failures++; $display("[TB] FAIL min_flag: got %b, expected 1", at_min); end
  endtask

  task automatic test_block();
    @(negedge clk);
    pidx.delete(); edge_no = 0;
    btn_up = 1'b1; btn_down = 1'b1;
    watch(20);
    btn_up = 1'b0;
    watch(20);
    assertions++; if (pidx.size() != 0) begin failures++; $display("[TB] FAIL block_pulses: got %0d, expected 0", pidx.size()); end
    assertions++; if (volume !== 4'd0) begin failures++; $display("[TB] FAIL block_volume: got %0d, expected 0", volume); end
    btn_down = 1'b0;
    watch(20);
    press(1'b1, 1'b0, 8, 20);
    assertions++; if (pidx.size() != 1 || pidx[0] != 7) begin failures++; $display("[TB] FAIL block_recover: got %0d pulses, expected one at edge 7", pidx.size()); end
    assertions++; if (volume !== 4'd1) begin failures++; $display("[TB] FAIL block_volume_after: got %0d, expected 1", volume); end
  endtask

  task automatic test_at_max();
    press(1'b1, 1'b0, 70, 20);
    assertions++; if (pidx.size() != 14) begin failures++; $display("[TB] FAIL max_pulses: got %0d, expected 14", pidx.size()); end
    assertions++; if (volume !== 4'd15) begin failures++; $display("[TB] FAIL max_volume: got %0d, expected 15", volume); end
    assertions++; if (at_max !== 1'b1 || at_min !== 1'b0) begin failures++; $display("[TB] FAIL max_flags: got at_max=%b at_min=%b, expected 1 0", at_max, at_min); end
    press(1'b1, 1'b0, 20, 20);
    assertions++; if (pidx.size() != 0 || volume !== 4'd15) begin failures++; $display("[TB] FAIL max_hold: got %0d pulses volume %0d, expected 0 pulses volume 15", pidx.size(), volume); end
  endtask

  task automatic test_reset_mid_repeat();
    @(negedge clk);
    pidx.delete(); edge_no = 0;
    btn_down = 1'b1;
    watch(25);
    assertions++; if (volume !== 4'd11) begin failures++; $display("[TB] FAIL midrep_pre: got %0d, expected 11", volume); end
    reset = 1'b1;
    watch(2);
    assertions++; if (volume !== 4'd8 || mudou_volume !== 1'b0) begin failures++; $display("[TB] FAIL midrep_reset: got volume %0d pulse %b, expected 8 0", volume, mudou_volume); end
    reset = 1'b0;
    pidx.delete();
    watch(40);
    assertions++; if (pidx.size() != 0 || volume !== 4'd8) begin failures++; $display("[TB] FAIL midrep_held: got %0d pulses volume %0d, expected 0 pulses volume 8", pidx.size(), volume); end
    btn_down = 1'b0;
    watch(20);
    press(1'b0, 1'b1, 8, 20);
    assertions++; if (pidx.size() != 1 || volume !== 4'd7) begin failures++; $display("[TB] FAIL midrep_repress: got %0d pulses volume %0d, expected 1 pulse volume 7", pidx.size(), volume); end
  endtask

  task automatic test_random();
    int sel, len, errs;
    errs = 0;
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 5);
      len = $urandom_range(1, 60);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        assertions++;
        if (volume !== 4'(m_vol) || mudou_volume !== m_pulse ||
            at_max !== (m_vol == VMAX) || at_min !== (m_vol == 0)) begin
          failures++;
          if (errs < 10) $display("[TB] FAIL random_cycle: got vol=%0d pulse=%b max=%b min=%b, expected vol=%0d pulse=%b",
                                  volume, mudou_volume, at_max, at_min, m_vol, m_pulse);
          errs++;
        end
        case (sel)
          0: begin btn_up = 1'b0; btn_down = 1'b0; end
          1: begin btn_up = 1'b1; btn_down = 1'b0; end
          2: begin btn_up = 1'b0; btn_down = 1'b1; end
          3: begin btn_up = 1'b1; btn_down = 1'b1; end
          4: begin btn_up = ($urandom_range(0, 3) != 0); btn_down = 1'b0; end
          default: begin btn_up = 1'b0; btn_down = ($urandom_range(0, 3) != 0); end
        endcase
      end
    end
    btn_up = 1'b0; btn_down = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    test_reset();
    test_glitch();
    test_single_step();
    test_repeat_down();
    test_at_min();
    test_block();
    test_at_max();
    test_reset_mid_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
